game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, the number of refresh ticks spent in SERVE before play.
REQ-002 SHALL have parameter LIVES_INIT, default 3, the lives loaded at game start (range 1..3).
REQ-003 SHALL have parameter HITS_PER_LVL, default 4, the paddle hits per speed-level increment.
REQ-004 SHALL have parameter MAX_LVL, default 7, the speed-level ceiling (range 1..15).
REQ-005 SHALL have port: clk  in  1  system clock; all state on rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: refresh_tick  in  1  one-cycle pulse per frame from the pixel engine.
REQ-008 SHALL have port: start  in  1  level button, synchronous to clk.
REQ-009 SHALL have port: pause  in  1  level button, synchronous to clk.
REQ-010 SHALL have port: paddle_hit  in  1  one-cycle pulse when the ball strikes the paddle.
REQ-011 SHALL have port: ball_miss  in  1  one-cycle pulse when the ball reaches the right edge.
REQ-012 SHALL have port: ball_en  out  1  pixel engine may advance the ball.
REQ-013 SHALL have port: ball_serve  out  1  one-cycle pulse; pixel engine reloads ball position and velocity.
REQ-014 SHALL have port: speed_lvl  out  4  added to ball velocity by the engine.
REQ-015 SHALL have port: score  out  16  hits in the current game.
REQ-016 SHALL have port: high_score  out  16  best score since reset.
REQ-017 SHALL have port: lives  out  2  remaining lives.
REQ-018 SHALL have port: state  out  3  current FSM state encoding.
REQ-019 SHALL have port: game_over  out  1  high while in OVER.

Function
REQ-020 SHALL implement states IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, PAUSE=5; all outputs registered.
REQ-021 SHALL detect a start press as the cycle where start=1 and the registered start is 0; the same edge rule applies to pause.
REQ-022 SHALL, on a start press in IDLE or OVER, clear score, speed_lvl and the hit counter, load lives=LIVES_INIT, and enter SERVE.
REQ-023 SHALL assert ball_serve for exactly the first cycle in SERVE, clear the frame counter, and move to PLAY on the cycle after the SERVE_FRAMES-th refresh_tick.
REQ-024 SHALL drive ball_en=1 only in PLAY.
REQ-025 SHALL, on paddle_hit in PLAY, increment score saturating at 16'hFFFF, and increment the hit counter.
REQ-026 SHALL, when the hit counter reaches HITS_PER_LVL, reset it to 0 and increment speed_lvl saturating at MAX_LVL.
REQ-027 SHALL, on ball_miss in PLAY, enter MISS; when paddle_hit and ball_miss coincide, the miss wins and score is unchanged.
REQ-028 SHALL, in MISS (one cycle), decrement lives and clear speed_lvl and the hit counter, then enter OVER if lives was 1, else SERVE.
REQ-029 SHALL, on entry to OVER, set high_score to score if score > high_score, and assert game_over.
REQ-030 SHALL ignore paddle_hit and ball_miss outside PLAY, and ignore start outside IDLE and OVER.
REQ-031 SHALL leave IDLE only on a start press.

Reset
REQ-032 SHALL, while reset=0, force state=IDLE, score=0, high_score=0, lives=0, speed_lvl=0, ball_en=0, ball_serve=0, game_over=0, and clear all counters.
REQ-033 SHALL, when reset asserts mid-game, drop immediately to IDLE, lose the high score, and require a start press after release.

Configuration
REQ-034 SHALL, with GAME_CTRL_PAUSE_EN defined, enter PAUSE on a pause press in PLAY and return to PLAY on the next press; in PAUSE ball_en=0 and refresh ticks are not counted.
REQ-035 SHALL, without GAME_CTRL_PAUSE_EN, keep the pause port but ignore it and leave PAUSE unreachable.

Structure
REQ-036 SHALL place the state encoding constants, the score width (16) and the speed_lvl width (4) in package game_pkg.
REQ-037 SHALL instantiate one sub-module, frame_timer, which counts refresh_tick up to SERVE_FRAMES and has a clear input and a done output.

Verification
REQ-038 SHALL verify: reset release, start press -> after 1 cycle state=SERVE, lives=3, ball_serve high for 1 cycle.
REQ-039 SHALL verify: in SERVE, 60 refresh ticks -> state=PLAY the next cycle, ball_en=1; 59 ticks -> still SERVE.
REQ-040 SHALL verify: 9 paddle_hit pulses in PLAY -> score=9, speed_lvl=2; 40 hits -> speed_lvl=7 (saturated).
REQ-041 SHALL verify: paddle_hit and ball_miss in the same cycle -> score unchanged, MISS, then SERVE with lives=2, speed_lvl=0.
REQ-042 SHALL verify: three misses after score 5 -> OVER, game_over=1, high_score=5; new game scoring 3 -> high_score stays 5.
REQ-043 SHALL verify: with GAME_CTRL_PAUSE_EN, a pause press in PLAY -> PAUSE with ball_en=0; a second press -> PLAY; without the macro, pause has no effect.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
//  Module      : game_pkg
//  Description : Shared constants and state encoding for the game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int c_score_w = 16;
    localparam int c_lvl_w   = 4;
    localparam int c_state_w = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/game_ctrl_if.sv
// ============================================================================
//  Module      : game_ctrl_if
//  Description : Signal bundle between the pixel engine / buttons (master)
//                and the game controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_ctrl_if;
    import game_pkg::*;

    logic                 refresh_tick;
    logic                 start;
    logic                 pause;
    logic                 paddle_hit;
    logic                 ball_miss;
    logic                 ball_en;
    logic                 ball_serve;
    logic [c_lvl_w-1:0]   speed_lvl;
    logic [c_score_w-1:0] score;
    logic [c_score_w-1:0] high_score;
    logic [1:0]           lives;
    logic [c_state_w-1:0] state;
    logic                 game_over;

    modport master (
        output refresh_tick, start, pause, paddle_hit, ball_miss,
        input  ball_en, ball_serve, speed_lvl, score, high_score, lives, state, game_over
    );

    modport slave (
        input  refresh_tick, start, pause, paddle_hit, ball_miss,
        output ball_en, ball_serve, speed_lvl, score, high_score, lives, state, game_over
    );

endinterface

`default_nettype wire

// File: rtl/game_ctrl_frame_timer.sv
// ============================================================================
//  Module      : frame_timer
//  Description : Counts refresh ticks; done pulses on the SERVE_FRAMES-th tick
//                since the last clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_timer #(
    parameter int SERVE_FRAMES = 60
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic refresh_tick,
    output logic      done
);

    localparam int c_cnt_w = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    logic [c_cnt_w-1:0] r_count;

    assign done = refresh_tick && (r_count == c_cnt_w'(SERVE_FRAMES - 1));

    // Tick counter, cleared externally or when the target count is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || done) begin
            r_count <= '0;
        end else if (refresh_tick) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
//  Module      : game_ctrl
//  Description : Paddle-game controller: serve timing, scoring, speed levels,
//                lives and high score. Optional pause feature enabled by
//                defining GAME_CTRL_PAUSE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int LIVES_INIT   = 3,
    parameter int HITS_PER_LVL = 4,
    parameter int MAX_LVL      = 7
) (
    input  wire logic  clk,
    input  wire logic  reset,
    game_ctrl_if.slave bus
);

    localparam int c_hit_w = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;

    state_t               r_state;
    state_t               w_next;
    logic                 r_start_q;
    logic                 w_start_press;
    logic                 w_frames_done;
    logic [c_score_w-1:0] r_score;
    logic [c_score_w-1:0] r_high_score;
    logic [c_lvl_w-1:0]   r_speed_lvl;
    logic [c_hit_w-1:0]   r_hits;
    logic [1:0]           r_lives;
    logic                 r_ball_en;
    logic                 r_ball_serve;
    logic                 r_game_over;

    assign w_start_press = bus.start && !r_start_q;

`ifdef GAME_CTRL_PAUSE_EN
    logic r_pause_q;
    logic w_pause_press;

    assign w_pause_press = bus.pause && !r_pause_q;

    // Pause button history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pause_q <= 1'b0;
        end else begin
            r_pause_q <= bus.pause;
        end
    end
`endif

    // Serve delay only runs while serving; any other state holds it cleared.
    frame_timer #(
        .SERVE_FRAMES (SERVE_FRAMES)
    ) u_frame_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (r_state != ST_SERVE),
        .refresh_tick (bus.refresh_tick),
        .done         (w_frames_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision; a miss takes priority over a simultaneous pause.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_press) w_next = ST_SERVE;
            ST_SERVE: if (w_frames_done) w_next = ST_PLAY;
            ST_PLAY: begin
                if (bus.ball_miss) begin
                    w_next = ST_MISS;
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (w_pause_press) begin
                    w_next = ST_PAUSE;
                end
`endif
            end
            ST_MISS:  w_next = (r_lives == 2'd1) ? ST_OVER : ST_SERVE;
            ST_OVER:  if (w_start_press) w_next = ST_SERVE;
`ifdef GAME_CTRL_PAUSE_EN
            ST_PAUSE: if (w_pause_press) w_next = ST_PLAY;
`endif
            default:  w_next = ST_IDLE;
        endcase
    end

    // Game data and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_q    <= 1'b0;
            r_score      <= '0;
            r_high_score <= '0;
            r_speed_lvl  <= '0;
            r_hits       <= '0;
            r_lives      <= '0;
            r_ball_en    <= 1'b0;
            r_ball_serve <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_start_q    <= bus.start;
            r_ball_en    <= (w_next == ST_PLAY);
            r_ball_serve <= (w_next == ST_SERVE) && (r_state != ST_SERVE);
            r_game_over  <= (w_next == ST_OVER);

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (w_start_press) begin
                        r_score     <= '0;
                        r_speed_lvl <= '0;
                        r_hits      <= '0;
                        r_lives     <= 2'(LIVES_INIT);
                    end
                end
                ST_PLAY: begin
                    if (bus.paddle_hit && !bus.ball_miss) begin
                        if (r_score != '1) begin
                            r_score <= r_score + c_score_w'(1);
                        end
                        if (r_hits == c_hit_w'(HITS_PER_LVL - 1)) begin
                            r_hits <= '0;
                            if (r_speed_lvl != c_lvl_w'(MAX_LVL)) begin
                                r_speed_lvl <= r_speed_lvl + c_lvl_w'(1);
                            end
                        end else begin
                            r_hits <= r_hits + c_hit_w'(1);
                        end
                    end
                end
                ST_MISS: begin
                    r_lives     <= r_lives - 2'd1;
                    r_speed_lvl <= '0;
                    r_hits      <= '0;
                end
                default: ;
            endcase

            if ((w_next == ST_OVER) && (r_state != ST_OVER) && (r_score > r_high_score)) begin
                r_high_score <= r_score;
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.score      = r_score;
    assign bus.high_score = r_high_score;
    assign bus.speed_lvl  = r_speed_lvl;
    assign bus.lives      = r_lives;
    assign bus.ball_en    = r_ball_en;
    assign bus.ball_serve = r_ball_serve;
    assign bus.game_over  = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
//  Module      : tb_game_ctrl
//  Description : Self-checking bench for game_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    localparam int SERVE_FRAMES = 60;
    localparam int LIVES_INIT   = 3;
    localparam int HITS_PER_LVL = 4;
    localparam int MAX_LVL      = 7;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4, S_PAUSE = 5;

`ifdef GAME_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    game_ctrl_if bus ();

    game_ctrl #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .LIVES_INIT   (LIVES_INIT),
        .HITS_PER_LVL (HITS_PER_LVL),
        .MAX_LVL      (MAX_LVL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_st, m_score, m_high, m_lives, m_lvl, m_hits, m_frames;
    bit m_serve, m_sq, m_pq;

    task automatic model_reset();
        m_st = S_IDLE; m_score = 0; m_high = 0; m_lives = 0; m_lvl = 0;
        m_hits = 0; m_frames = 0; m_serve = 0; m_sq = 0; m_pq = 0;
    endtask

    task automatic model_step(input bit tick, input bit st, input bit pz, input bit hit, input bit miss);
        int prev;
        bit sp, pp;
        sp = st && !m_sq;
        pp = pz && !m_pq;
        m_sq = st;
        m_pq = pz;
        prev = m_st;
        case (m_st)
            S_IDLE, S_OVER: if (sp) begin
                m_score = 0; m_lvl = 0; m_hits = 0; m_lives = LIVES_INIT; m_st = S_SERVE;
            end
            S_SERVE: if (tick) begin
                m_frames++;
                if (m_frames == SERVE_FRAMES) m_st = S_PLAY;
            end
            S_PLAY: begin
                if (miss) begin
                    m_st = S_MISS;
                end else begin
                    if (hit) begin
                        if (m_score < 65535) m_score++;
                        m_hits++;
                        if (m_hits == HITS_PER_LVL) begin
                            m_hits = 0;
                            if (m_lvl < MAX_LVL) m_lvl++;
                        end
                    end
                    if (PAUSE_EN && pp) m_st = S_PAUSE;
                end
            end
            S_MISS: begin
                m_lives--; m_lvl = 0; m_hits = 0;
                m_st = (m_lives == 0) ? S_OVER : S_SERVE;
            end
            S_PAUSE: if (pp) m_st = S_PLAY;
            default: ;
        endcase
        m_serve = (m_st == S_SERVE) && (prev != S_SERVE);
        if (m_serve) m_frames = 0;
        if (m_st == S_OVER && prev != S_OVER && m_score > m_high) m_high = m_score;
    endtask

    task automatic step(input bit tick, input bit st, input bit pz, input bit hit, input bit miss);
        @(negedge clk);
        bus.refresh_tick = tick;
        bus.start        = st;
        bus.pause        = pz;
        bus.paddle_hit   = hit;
        bus.ball_miss    = miss;
        model_step(tick, st, pz, hit, miss);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.refresh_tick = 0; bus.start = 0; bus.pause = 0; bus.paddle_hit = 0; bus.ball_miss = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic start_game();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic serve_done();
        repeat (SERVE_FRAMES) step(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [43:0] got;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.state, bus.score, bus.high_score, bus.lives, bus.speed_lvl,
               bus.ball_en, bus.ball_serve, bus.game_over};
        n_cmp++;
        if (got !== 44'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, 44'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(1, 0, 1, 1, 1);
        n_cmp++;
        if (bus.state !== 3'(S_IDLE)) begin
            n_err++;
            $display("FAIL idle_hold: state got %0d want %0d", bus.state, S_IDLE);
        end
    endtask

    task automatic test_start();
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_SERVE) || bus.lives !== 2'd3 || bus.ball_serve !== 1'b1) begin
            n_err++;
            $display("FAIL start_press: state/lives/serve got %0d/%0d/%0d want 1/3/1",
                     bus.state, bus.lives, bus.ball_serve);
        end
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_SERVE) || bus.ball_serve !== 1'b0) begin
            n_err++;
            $display("FAIL serve_pulse_width: state/serve got %0d/%0d want 1/0", bus.state, bus.ball_serve);
        end
    endtask

    task automatic test_serve();
        repeat (SERVE_FRAMES - 1) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_SERVE) || bus.ball_en !== 1'b0) begin
            n_err++;
            $display("FAIL serve_59_ticks: state/en got %0d/%0d want 1/0", bus.state, bus.ball_en);
        end
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_PLAY) || bus.ball_en !== 1'b1) begin
            n_err++;
            $display("FAIL serve_60_ticks: state/en got %0d/%0d want 2/1", bus.state, bus.ball_en);
        end
    endtask

    task automatic test_hits();
        repeat (9) step(0, 0, 0, 1, 0);
        n_cmp++;
        if (bus.score !== 16'd9 || bus.speed_lvl !== 4'd2) begin
            n_err++;
            $display("FAIL hits_9: score/lvl got %0d/%0d want 9/2", bus.score, bus.speed_lvl);
        end
        repeat (31) step(0, 0, 0, 1, 0);
        n_cmp++;
        if (bus.score !== 16'd40 || bus.speed_lvl !== 4'(MAX_LVL)) begin
            n_err++;
            $display("FAIL hits_40: score/lvl got %0d/%0d want 40/%0d", bus.score, bus.speed_lvl, MAX_LVL);
        end
    endtask

    task automatic test_coincide();
        step(0, 0, 0, 1, 1);
        n_cmp++;
        if (bus.state !== 3'(S_MISS) || bus.score !== 16'd40 || bus.ball_en !== 1'b0) begin
            n_err++;
            $display("FAIL hit_miss_same: state/score/en got %0d/%0d/%0d want 3/40/0",
                     bus.state, bus.score, bus.ball_en);
        end
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_SERVE) || bus.lives !== 2'd2 || bus.speed_lvl !== 4'd0 || bus.ball_serve !== 1'b1) begin
            n_err++;
            $display("FAIL after_miss: state/lives/lvl/serve got %0d/%0d/%0d/%0d want 1/2/0/1",
                     bus.state, bus.lives, bus.speed_lvl, bus.ball_serve);
        end
    endtask

    task automatic lose_game(input int hits);
        serve_done();
        repeat (hits) step(0, 0, 0, 1, 0);
        repeat (LIVES_INIT - 1) begin
            step(0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0);
            serve_done();
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_over();
        do_reset();
        start_game();
        lose_game(5);
        n_cmp++;
        if (bus.state !== 3'(S_OVER) || bus.game_over !== 1'b1 || bus.high_score !== 16'd5 || bus.lives !== 2'd0) begin
            n_err++;
            $display("FAIL game_over_1: state/over/high/lives got %0d/%0d/%0d/%0d want 4/1/5/0",
                     bus.state, bus.game_over, bus.high_score, bus.lives);
        end
        repeat (3) step(1, 0, 0, 1, 1);
        n_cmp++;
        if (bus.state !== 3'(S_OVER) || bus.score !== 16'd5) begin
            n_err++;
            $display("FAIL over_hold: state/score got %0d/%0d want 4/5", bus.state, bus.score);
        end
        start_game();
        n_cmp++;
        if (bus.score !== 16'd0 || bus.lives !== 2'd3 || bus.game_over !== 1'b0) begin
            n_err++;
            $display("FAIL restart: score/lives/over got %0d/%0d/%0d want 0/3/0",
                     bus.score, bus.lives, bus.game_over);
        end
        lose_game(3);
        n_cmp++;
        if (bus.state !== 3'(S_OVER) || bus.score !== 16'd3 || bus.high_score !== 16'd5) begin
            n_err++;
            $display("FAIL game_over_2: state/score/high got %0d/%0d/%0d want 4/3/5",
                     bus.state, bus.score, bus.high_score);
        end
    endtask

    task automatic test_pause();
        int exp_st;
        start_game();
        serve_done();
        step(0, 0, 1, 0, 0);
        exp_st = PAUSE_EN ? S_PAUSE : S_PLAY;
        n_cmp++;
        if (bus.state !== 3'(exp_st) || bus.ball_en !== !PAUSE_EN) begin
            n_err++;
            $display("FAIL pause_press: state/en got %0d/%0d want %0d/%0d",
                     bus.state, bus.ball_en, exp_st, !PAUSE_EN);
        end
        repeat (4) step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(exp_st)) begin
            n_err++;
            $display("FAIL pause_hold: state got %0d want %0d", bus.state, exp_st);
        end
        step(0, 0, 1, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_PLAY) || bus.ball_en !== 1'b1) begin
            n_err++;
            $display("FAIL pause_release: state/en got %0d/%0d want 2/1", bus.state, bus.ball_en);
        end
    endtask

    task automatic test_reset_mid();
        repeat (6) step(0, 0, 0, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.state !== 3'(S_IDLE) || bus.high_score !== 16'd0 || bus.score !== 16'd0 || bus.lives !== 2'd0) begin
            n_err++;
            $display("FAIL async_reset: state/high/score/lives got %0d/%0d/%0d/%0d want 0/0/0/0",
                     bus.state, bus.high_score, bus.score, bus.lives);
        end
        bus.start = 0; bus.pause = 0; bus.paddle_hit = 0; bus.ball_miss = 0; bus.refresh_tick = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(1, 0, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'(S_IDLE)) begin
            n_err++;
            $display("FAIL post_reset_idle: state got %0d want 0", bus.state);
        end
    endtask

    task automatic test_random();
        logic [43:0] got, exp;
        bit tick, st, pz, hit, miss;
        for (int i = 0; i < 4000; i++) begin
            tick = ($urandom_range(0, 1) == 1);
            st   = ($urandom_range(0, 25) == 0);
            pz   = ($urandom_range(0, 30) == 0);
            hit  = ($urandom_range(0, 3) == 0);
            miss = ($urandom_range(0, 40) == 0);
            step(tick, st, pz, hit, miss);
            exp = {3'(m_st), 16'(m_score), 16'(m_high), 2'(m_lives), 4'(m_lvl),
                   (m_st == S_PLAY), m_serve, (m_st == S_OVER)};
            got = {bus.state, bus.score, bus.high_score, bus.lives, bus.speed_lvl,
                   bus.ball_en, bus.ball_serve, bus.game_over};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.refresh_tick = 0; bus.start = 0; bus.pause = 0; bus.paddle_hit = 0; bus.ball_miss = 0;
        model_reset();
        test_reset();
        test_start();
        test_serve();
        test_hits();
        test_coincide();
        test_over();
        test_pause();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
